// File: rtl/enemy_sprite_renderer.sv
// Multi-slot enemy sprite renderer: two-stage pixel pipeline, per-slot hit flash, animation phase.
// Optional feature macro: ENEMY_HIT_FLASH_EN builds the per-slot hit-flash counters.
module enemy_sprite_renderer #(
  parameter int N_ENEMY      = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int ANIM_FRAMES  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  input  logic                   frame_start,
  input  logic [N_ENEMY-1:0]     enemy_active,
  input  logic [10*N_ENEMY-1:0]  enemy_x,
  input  logic [10*N_ENEMY-1:0]  enemy_y,
  input  logic [2*N_ENEMY-1:0]   enemy_type,
  input  logic [4*N_ENEMY-1:0]   enemy_health,
  input  logic [N_ENEMY-1:0]     hit_pulse,
  output logic [23:0]            rgb_out,
  output logic                   rgb_valid,
  output logic                   pix_hit,
  output logic [2:0]             pix_id
);

  typedef enum logic [1:0] {
    TYPE_BOX     = 2'd0,
    TYPE_CROSS   = 2'd1,
    TYPE_DIAMOND = 2'd2,
    TYPE_ANIM    = 2'd3
  } sprite_type_e;

  localparam logic [23:0] RGB_BLACK = 24'h000000;

  function automatic logic signed [10:0] offset(input logic [9:0] pos, input logic [9:0] centre);
    return $signed({1'b0, pos}) - $signed({1'b0, centre});
  endfunction

  function automatic logic sprite_lit(input logic signed [10:0] dx, input logic signed [10:0] dy,
                                      input sprite_type_e typ, input logic phase);
    logic signed [11:0] tx, ty;
    logic [11:0]        ax, ay;
    logic               in_box, border;
    // 2*d+1 keeps the half-pixel sprite centre on an integer grid
    tx     = {dx, 1'b1};
    ty     = {dy, 1'b1};
    ax     = tx[11] ? -tx : tx;
    ay     = ty[11] ? -ty : ty;
    in_box = (dx >= -11'sd8) && (dx <= 11'sd7) && (dy >= -11'sd8) && (dy <= 11'sd7);
    border = (dx == -11'sd8) || (dx == 11'sd7) || (dy == -11'sd8) || (dy == 11'sd7);
    case (typ)
      TYPE_BOX:     sprite_lit = in_box;
      TYPE_CROSS:   sprite_lit = in_box && (((dx >= -11'sd4) && (dx <= 11'sd3)) ||
                                            ((dy >= -11'sd3) && (dy <= 11'sd2)));
      TYPE_DIAMOND: sprite_lit = in_box && ((ax + ay) <= 12'd16);
      default:      sprite_lit = in_box && (!phase || border);
    endcase
  endfunction

  function automatic logic [23:0] sprite_rgb(input logic flash, input sprite_type_e typ,
                                             input logic [3:0] health);
    if (flash)               return 24'h00FFFF;
    else if (typ == TYPE_BOX) return 24'hFF0000;
    else if (health >= 4'd4) return 24'hFFFFFF;
    else if (health == 4'd3) return 24'hFF00FF;
    else if (health == 4'd2) return 24'hFFF000;
    else                     return 24'hFF0000;
  endfunction

  // Animation phase: toggles each time the frame counter wraps.
  logic [5:0] anim_cnt_q, anim_cnt_d;
  logic       phase_q, phase_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    anim_cnt_d = anim_cnt_q;
    phase_d    = phase_q;
    if (frame_start) begin
      if (anim_cnt_q == 6'(ANIM_FRAMES - 1)) begin
        anim_cnt_d = '0;
        phase_d    = ~phase_q;
      end else begin
        anim_cnt_d = anim_cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) begin
      anim_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      anim_cnt_q <= anim_cnt_d;
      phase_q    <= phase_d;
    end
  end

  logic [N_ENEMY-1:0] flash_on;

`ifdef ENEMY_HIT_FLASH_EN
  logic [4*N_ENEMY-1:0] flash_q, flash_d;

  always_comb begin
    flash_d = flash_q;
    for (int i = 0; i < N_ENEMY; i++) begin
      if (!enemy_active[i])
        flash_d[4*i +: 4] = 4'd0;
      else if (hit_pulse[i])
        flash_d[4*i +: 4] = 4'(FLASH_FRAMES);
      else if (frame_start && (flash_q[4*i +: 4] != 4'd0))
        flash_d[4*i +: 4] = flash_q[4*i +: 4] - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flash_q <= '0;
    else     flash_q <= flash_d;
  end

  always_comb begin
    flash_on = '0;
    for (int i = 0; i < N_ENEMY; i++) flash_on[i] = |flash_q[4*i +: 4];
  end
`else
  logic unused_hit_pulse;
  assign unused_hit_pulse = ^hit_pulse;
  assign flash_on         = '0;
`endif

  // Stage 1: per-slot coverage and a snapshot of the colour-relevant slot state.
  logic [N_ENEMY-1:0]   cover_d, cover_q, flash_on_q;
  logic [2*N_ENEMY-1:0] type_q;
  logic [4*N_ENEMY-1:0] health_q;
  logic                 valid1_q;

  always_comb begin
    cover_d = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      cover_d[i] = pix_valid && enemy_active[i] &&
                   sprite_lit(offset(hcount, enemy_x[10*i +: 10]),
                              offset(vcount, enemy_y[10*i +: 10]),
                              sprite_type_e'(enemy_type[2*i +: 2]), phase_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cover_q    <= '0;
      flash_on_q <= '0;
      type_q     <= '0;
      health_q   <= '0;
      valid1_q   <= 1'b0;
    end else begin
      cover_q    <= cover_d;
      flash_on_q <= flash_on;
      type_q     <= enemy_type;
      health_q   <= enemy_health;
      valid1_q   <= pix_valid;
    end
  end

  // Stage 2: lowest covering slot wins; outputs are zero whenever the pixel is not valid.
  logic [23:0] rgb_d, rgb_q;
  logic        hit_d, hit_q, valid2_q;
  logic [2:0]  id_d, id_q;

  always_comb begin
    rgb_d = RGB_BLACK;
    hit_d = 1'b0;
    id_d  = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (cover_q[i]) begin
        hit_d = 1'b1;
        id_d  = 3'(i);
        rgb_d = sprite_rgb(flash_on_q[i], sprite_type_e'(type_q[2*i +: 2]), health_q[4*i +: 4]);
      end
    end
    if (!valid1_q) begin
      rgb_d = RGB_BLACK;
      hit_d = 1'b0;
      id_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q    <= RGB_BLACK;
      hit_q    <= 1'b0;
      id_q     <= '0;
      valid2_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hit_q    <= hit_d;
      id_q     <= id_d;
      valid2_q <= valid1_q;
    end
  end

  assign rgb_out   = rgb_q;
  assign rgb_valid = valid2_q;
  assign pix_hit   = hit_q;
  assign pix_id    = id_q;

endmodule

// File: tb/tb_enemy_sprite_renderer.sv
// Directed bench for enemy_sprite_renderer (N_ENEMY=4, FLASH_FRAMES=8, ANIM_FRAMES=2).
module tb_enemy_sprite_renderer;
  localparam int N = 4;
  localparam int ANIM = 2;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BLACK   = 24'h000000;
`ifdef ENEMY_HIT_FLASH_EN
  localparam logic [23:0] FLASHC  = 24'h00FFFF;
`else
  localparam logic [23:0] FLASHC  = WHITE;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            pix_valid;
  logic [9:0]      hcount, vcount;
  logic            frame_start;
  logic [N-1:0]    enemy_active;
  logic [10*N-1:0] enemy_x, enemy_y;
  logic [2*N-1:0]  enemy_type;
  logic [4*N-1:0]  enemy_health;
  logic [N-1:0]    hit_pulse;
  logic [23:0]     rgb_out;
  logic            rgb_valid, pix_hit;
  logic [2:0]      pix_id;

  int checks = 0;
  int errors = 0;
  int anim_cnt = 0;
  bit phase = 1'b0;

  enemy_sprite_renderer #(.N_ENEMY(N), .FLASH_FRAMES(8), .ANIM_FRAMES(ANIM)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .enemy_active(enemy_active), .enemy_x(enemy_x),
    .enemy_y(enemy_y), .enemy_type(enemy_type), .enemy_health(enemy_health),
    .hit_pulse(hit_pulse), .rgb_out(rgb_out), .rgb_valid(rgb_valid),
    .pix_hit(pix_hit), .pix_id(pix_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic act, input logic [9:0] x, input logic [9:0] y,
                          input logic [1:0] t, input logic [3:0] h);
    enemy_active[i]       = act;
    enemy_x[10*i +: 10]   = x;
    enemy_y[10*i +: 10]   = y;
    enemy_type[2*i +: 2]  = t;
    enemy_health[4*i +: 4] = h;
  endtask

  // One valid pixel; output must be absent after one edge and present after two.
  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic [23:0] exp_rgb,
                     input logic exp_hit, input logic [2:0] exp_id, input string tag);
    hcount = h; vcount = v; pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    check({tag, "_early_valid"}, 32'(rgb_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(rgb_valid), 32'd1);
    check({tag, "_rgb"},   32'(rgb_out),   32'(exp_rgb));
    check({tag, "_hit"},   32'(pix_hit),   32'(exp_hit));
    check({tag, "_id"},    32'(pix_id),    32'(exp_id));
  endtask

  task automatic anim_model_step();
    if (anim_cnt == ANIM - 1) begin anim_cnt = 0; phase = ~phase; end
    else anim_cnt++;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    anim_model_step();
  endtask

  task automatic hit(input int i, input bit with_frame);
    hit_pulse[i] = 1'b1;
    frame_start  = with_frame;
    @(posedge clk); #1;
    hit_pulse    = '0;
    frame_start  = 1'b0;
    if (with_frame) anim_model_step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; pix_valid = 1'b0; hcount = '0; vcount = '0; frame_start = 1'b0;
    enemy_active = '0; enemy_x = '0; enemy_y = '0; enemy_type = '0; enemy_health = '0;
    hit_pulse = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rgb_valid), 32'd0);
    check("rst_rgb",   32'(rgb_out),   32'd0);
    check("rst_hit",   32'(pix_hit),   32'd0);
    check("rst_id",    32'(pix_id),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Type 0 box at (100,100)
    set_slot(0, 1'b1, 10'd100, 10'd100, 2'd0, 4'd0);
    pix(10'd92,  10'd92,  RED,   1'b1, 3'd0, "box_tl");
    pix(10'd107, 10'd107, RED,   1'b1, 3'd0, "box_br");
    pix(10'd108, 10'd100, BLACK, 1'b0, 3'd0, "box_right_out");
    pix(10'd100, 10'd91,  BLACK, 1'b0, 3'd0, "box_top_out");
    enemy_health[3:0] = 4'd4;
    pix(10'd100, 10'd100, RED,   1'b1, 3'd0, "box_ignores_health");

    // Animated type 3 at (300,300), ANIM_FRAMES=2
    set_slot(0, 1'b1, 10'd300, 10'd300, 2'd3, 4'd4);
    pix(10'd300, 10'd300, WHITE, 1'b1, 3'd0, "anim_p0_centre");
    pix(10'd292, 10'd300, WHITE, 1'b1, 3'd0, "anim_p0_edge");
    frame_pulse();
    pix(10'd300, 10'd300, WHITE, 1'b1, 3'd0, "anim_f1_centre");
    frame_pulse();
    pix(10'd300, 10'd300, BLACK, 1'b0, 3'd0, "anim_p1_centre");
    pix(10'd292, 10'd300, WHITE, 1'b1, 3'd0, "anim_p1_edge");
    pix(10'd307, 10'd307, WHITE, 1'b1, 3'd0, "anim_p1_corner");
    frame_pulse();
    frame_pulse();
    pix(10'd300, 10'd300, WHITE, 1'b1, 3'd0, "anim_p0_again");

    // Overlap: diamond (slot 0, health 3) over cross (slot 1, health 4)
    set_slot(0, 1'b1, 10'd200, 10'd200, 2'd2, 4'd3);
    set_slot(1, 1'b1, 10'd200, 10'd200, 2'd1, 4'd4);
    pix(10'd200, 10'd200, MAGENTA, 1'b1, 3'd0, "ovl_centre");
    pix(10'd196, 10'd204, MAGENTA, 1'b1, 3'd0, "diamond_edge_in");
    pix(10'd204, 10'd204, BLACK,   1'b0, 3'd0, "diamond_edge_out");
    pix(10'd192, 10'd192, BLACK,   1'b0, 3'd0, "both_corner_out");
    enemy_active[0] = 1'b0;
    pix(10'd200, 10'd200, WHITE, 1'b1, 3'd1, "cross_centre");
    pix(10'd192, 10'd200, WHITE, 1'b1, 3'd1, "cross_hbar");
    pix(10'd203, 10'd207, WHITE, 1'b1, 3'd1, "cross_vbar");
    pix(10'd204, 10'd203, BLACK, 1'b0, 3'd0, "cross_gap");

    // Hit flash on slot 1
    hit(1, 1'b0);
    pix(10'd200, 10'd200, FLASHC, 1'b1, 3'd1, "flash_start");
    repeat (7) frame_pulse();
    pix(10'd200, 10'd200, FLASHC, 1'b1, 3'd1, "flash_after7");
    frame_pulse();
    pix(10'd200, 10'd200, WHITE,  1'b1, 3'd1, "flash_after8");
    hit(1, 1'b0);
    repeat (3) frame_pulse();
    hit(1, 1'b1);
    repeat (7) frame_pulse();
    pix(10'd200, 10'd200, FLASHC, 1'b1, 3'd1, "flash_reload7");
    frame_pulse();
    pix(10'd200, 10'd200, WHITE,  1'b1, 3'd1, "flash_reload8");
    hit(1, 1'b0);
    enemy_active[1] = 1'b0;
    @(posedge clk); #1;
    enemy_active[1] = 1'b1;
    pix(10'd200, 10'd200, WHITE,  1'b1, 3'd1, "flash_cleared_inactive");

    // Screen edge: no wrap of the offset
    enemy_active = '0;
    set_slot(0, 1'b1, 10'd3, 10'd240, 2'd0, 4'd0);
    pix(10'd0,    10'd240, RED,   1'b1, 3'd0, "edge_x0");
    pix(10'd10,   10'd240, RED,   1'b1, 3'd0, "edge_x10");
    pix(10'd11,   10'd240, BLACK, 1'b0, 3'd0, "edge_x11");
    pix(10'd635,  10'd240, BLACK, 1'b0, 3'd0, "edge_x635");
    pix(10'd1019, 10'd240, BLACK, 1'b0, 3'd0, "edge_x1019");

    // Mid-burst reset with phase=1, anim count=1 and slot 1 flashing
    set_slot(0, 1'b1, 10'd300, 10'd300, 2'd3, 4'd4);
    set_slot(1, 1'b1, 10'd500, 10'd300, 2'd1, 4'd4);
    for (int k = 0; k < 8 && !(phase == 1'b1 && anim_cnt == 1); k++) frame_pulse();
    pix(10'd300, 10'd300, BLACK,  1'b0, 3'd0, "pre_rst_dark");
    hit(1, 1'b0);
    pix(10'd500, 10'd300, FLASHC, 1'b1, 3'd1, "pre_rst_flash");
    hcount = 10'd500; vcount = 10'd300; pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("burst_valid", 32'(rgb_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(rgb_valid), 32'd0);
    check("async_rst_rgb",   32'(rgb_out),   32'd0);
    check("async_rst_hit",   32'(pix_hit),   32'd0);
    check("async_rst_id",    32'(pix_id),    32'd0);
    anim_cnt = 0; phase = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0; pix_valid = 1'b0;
    @(posedge clk); #1;
    pix(10'd500, 10'd300, WHITE, 1'b1, 3'd1, "post_rst_flash_clr");
    pix(10'd300, 10'd300, WHITE, 1'b1, 3'd0, "post_rst_phase0");
    frame_pulse();
    pix(10'd300, 10'd300, WHITE, 1'b1, 3'd0, "post_rst_cnt_clr");
    frame_pulse();
    pix(10'd300, 10'd300, BLACK, 1'b0, 3'd0, "post_rst_toggle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/enemy_sprite_renderer.md
# enemy_sprite_renderer

Multi-enemy sprite renderer for the VGA pixel path: given the current scan position, it outputs the RGB of the highest-priority active enemy covering that pixel, or black. It generalises single-enemy combinational drawing to `N_ENEMY` parametrised slots and adds:
- a two-stage registered pixel pipeline;
- per-enemy hit-flash timers;
- a frame-driven animation phase;
- an owner-ID output for collision logic.

It sits between the game-state registers and the VGA colour mux.

## Interface
Parameters:
- `N_ENEMY`, 4, number of enemy slots (1..8)
- `FLASH_FRAMES`, 8, frames an enemy flashes after a hit (1..15)
- `ANIM_FRAMES`, 16, frames per animation phase (1..63)

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `pix_valid`  in  1  `hcount`/`vcount` valid this cycle
- `hcount`  in  10  current pixel x
- `vcount`  in  10  current pixel y
- `frame_start`  in  1  one-cycle pulse, once per frame
- `enemy_active`  in  N_ENEMY  slot enable
- `enemy_x`  in  10*N_ENEMY  sprite centre x; slot i at bits [10i+9:10i]
- `enemy_y`  in  10*N_ENEMY  sprite centre y, same packing
- `enemy_type`  in  2*N_ENEMY  sprite type
- `enemy_health`  in  4*N_ENEMY  health
- `hit_pulse`  in  N_ENEMY  one-cycle hit event per slot
- `rgb_out`  out  24  pixel colour
- `rgb_valid`  out  1  `rgb_out` valid
- `pix_hit`  out  1  some enemy covers this pixel
- `pix_id`  out  3  index of the covering enemy (0 when `pix_hit`=0)

## Operation
- Offsets: dx = hcount − x_i and dy = vcount − y_i, computed as signed 11-bit values (no 10-bit wrap). The sprite box is dx, dy ∈ [−8, 7].
- Sprite shapes (lit pixel, inside the box):
  - type 0: whole box.
  - type 1 (cross): |dx+0.5| < 4 or |dy+0.5| < 3.
  - type 2 (diamond): |dx+0.5| + |dy+0.5| ≤ 8.
  - type 3 (animated): phase 0 = whole box; phase 1 = border only, i.e. dx ∈ {−8, 7} or dy ∈ {−8, 7}.
- Coverage: slot i covers a pixel iff `enemy_active[i]` and the sprite is lit there.
- Priority: lowest covering index wins.
- Colour of the winning slot:
  - flash counter ≠ 0 → 00FFFF.
  - else type 0 → FF0000.
  - else by health: ≥4 → FFFFFF; 3 → FF00FF; 2 → FFF000; 0–1 → FF0000.
  - No cover → 000000.
- Flash counter per slot, 4 bits:
  - `hit_pulse[i]` loads `FLASH_FRAMES`.
  - else `frame_start` decrements it if non-zero.
  - A hit in the same cycle as `frame_start` → the load wins.
  - `enemy_active[i]`=0 forces it to 0 (clear beats load).
- Animation counter, 6 bits: increments on `frame_start`. On reaching `ANIM_FRAMES`−1 it wraps to 0 and toggles `phase`.

## Timing
- Stage 1 (registered): per-slot cover bits, `pix_valid`, and the latched type/health/flash state of every slot.
- Stage 2 (registered): priority encode and colour → `rgb_out`, `rgb_valid`, `pix_hit`, `pix_id`.
- Latency: exactly 2 cycles from `pix_valid` to `rgb_valid`. Throughput is 1 pixel/cycle.
- With `pix_valid`=0: the stage-1 valid is cleared, so `rgb_valid`=0 two cycles later. `rgb_out`/`pix_hit`/`pix_id` are forced to 0 when not valid.
- Updates from `hit_pulse` and `frame_start` affect pixels sampled by stage 1 on the following cycle.
- Reset (asynchronous, any time, including mid-line): all pipeline registers, `rgb_out`=0, `rgb_valid`=0, `pix_hit`=0, `pix_id`=0, flash counters 0, animation counter 0, `phase`=0. The first valid output after reset deassert is 2 cycles after `pix_valid`.
- Near the screen edges (x_i < 8, x_i > 631, etc.), only the in-range part of the sprite is drawn; no wrap to the opposite edge.

## Configuration
- `ENEMY_HIT_FLASH_EN`
  - Defined: flash counters exist and flash colour 00FFFF has top priority.
  - Undefined: no flash counters are synthesised, `hit_pulse` is ignored, and colour is from type/health only. Pipeline latency is unchanged.

## Test plan
- Slot 0 at (100,100), type 0, active; scan pixel (92,92) and (107,107) → FF0000 with `pix_id`=0; pixel (108,100) → 000000 with `pix_hit`=0, each 2 cycles after `pix_valid`.
- Slots 0 and 1 overlap at (200,200), types 2/1, health 3/4; pixel (200,200) → FF00FF, `pix_id`=0; deactivate slot 0 → FFFFFF, `pix_id`=1.
- `hit_pulse[1]` with `FLASH_FRAMES`=8 → slot 1 pixels 00FFFF for 8 `frame_start` pulses, then the health colour. A hit coinciding with `frame_start` reloads the counter to 8.
- Type 3 at (300,300), `ANIM_FRAMES`=2: pixel (300,300) lit in phase 0, dark after 2 `frame_start` pulses, lit again after 2 more; pixel (292,300) always lit.
- Slot at x=3: pixel (0,y) lit and pixel (635,y) unlit; assert `rst` mid-burst → outputs 0 immediately and all counters cleared.
- Compile without `ENEMY_HIT_FLASH_EN`: `hit_pulse` gives no colour change, and latency is still 2.
